imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts a raw instruction plus a tag (normally the PC) over a valid/ready handshake and classifies the instruction format. It produces the sign- or zero-extended immediate at XLEN bits, with one registered cycle of latency and a 2-entry skid buffer so decode can be back-pressured without bubbles. It replaces the earlier combinational immediate unit between fetch and register read, and adds illegal-opcode flagging, shift-amount and optional CSR handling, and a flush input.

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_gen_pipe_decode.sv | 88 ++++++++
 rtl/imm_gen_pipe.sv | 103 ++++++++++
 tb/tb_imm_gen_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_CSR  = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational format classification and immediate extraction.
// SYSTEM/CSR immediates are decoded only when IMM_GEN_CSR_EN is defined.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic        s;
  logic [2:0]  funct3;
  logic [63:0] w;

  assign s      = instr[31];
  assign funct3 = instr[14:12];

  // Built at 64 bits and truncated so one expression serves both XLEN values.
  always_comb begin
    w       = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        w   = {{32{s}}, instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        w   = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD: begin
        fmt = FMT_I;
        w   = {{52{s}}, instr[31:20]};
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt = FMT_SH;
          if (XLEN == 64) begin
            w = {58'b0, instr[25:20]};
          end else begin
            w       = {59'b0, instr[24:20]};
            illegal = instr[25];
          end
        end else begin
          fmt = FMT_I;
          w   = {{52{s}}, instr[31:20]};
        end
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        w   = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        w   = {{52{s}}, instr[31:25], instr[11:7]};
      end
      OPC_OP: begin
        fmt = FMT_NONE;
      end
`ifdef IMM_GEN_CSR_EN
      OPC_SYSTEM: begin
        case (funct3)
          3'b000:  fmt = FMT_NONE;
          3'b100:  illegal = 1'b1;
          default: begin
            fmt = FMT_CSR;
            w   = {47'b0, (funct3[2] ? instr[19:15] : 5'b0), instr[31:20]};
          end
        endcase
      end
`else
      OPC_SYSTEM: begin
        illegal = 1'b1;
      end
`endif
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(w);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage with a 2-entry skid buffer.
// Optional CSR decode is selected by IMM_GEN_CSR_EN in imm_decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output fmt_e             out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_illegal;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  fmt_e             main_fmt;
  logic             main_illegal;
  logic [TAG_W-1:0] main_tag;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  fmt_e             skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;

  logic             in_fire;
  logic             main_load;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign in_ready  = ~skid_valid;
  assign in_fire   = in_valid & in_ready;
  assign main_load = ~main_valid | out_ready;

  // Skid is only ever full while main is full, so draining skid into main
  // never coincides with an input being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_fmt     <= FMT_NONE;
      main_illegal <= 1'b0;
      main_tag     <= '0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        main_valid   <= 1'b1;
        main_imm     <= skid_imm;
        main_fmt     <= skid_fmt;
        main_illegal <= skid_illegal;
        main_tag     <= skid_tag;
        skid_valid   <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_imm     <= dec_imm;
          main_fmt     <= dec_fmt;
          main_illegal <= dec_illegal;
          main_tag     <= in_tag;
        end
      end
    end else if (in_fire) begin
      skid_valid   <= 1'b1;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
      skid_tag     <= in_tag;
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_fmt     = main_fmt;
  assign out_illegal = main_illegal;
  assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share stimulus and are
// compared every cycle against a queue model and a reference decoder.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [31:0] tag32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [31:0] tag64;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference decoder: field values from signed arithmetic on the instruction.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output logic [63:0] imm, output int fmt, output bit ill);
    int     f3;
    longint v;
    f3 = int'(ins[14:12]);
    v = 0; fmt = 0; ill = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin fmt = 4; v = longint'($signed({ins[31:12], 12'h000})); end
      7'h6F: begin fmt = 5; v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      7'h67, 7'h03: begin fmt = 1; v = longint'($signed(ins[31:20])); end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = 6;
          v   = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
          ill = !x64 && ins[25];
        end else begin
          fmt = 1; v = longint'($signed(ins[31:20]));
        end
      end
      7'h63: begin fmt = 3; v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h23: begin fmt = 2; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h33: ;
      7'h73: begin
`ifdef IMM_GEN_CSR_EN
        if (f3 == 4) ill = 1'b1;
        else if (f3 != 0) begin
          fmt = 7;
          v   = longint'(ins[31:20]) + ((f3 >= 4) ? longint'(ins[19:15]) * 4096 : 0);
        end
`else
        ill = 1'b1;
`endif
      end
      default: ill = 1'b1;
    endcase
    imm = x64 ? 64'(v) : {32'b0, v[31:0]};
  endfunction

  // Queue model: capacity 2, pop before push, flush and reset empty it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (flush) q.delete();
    else begin
      int sz0;
      entry_t e;
      sz0 = q.size();
      if (sz0 > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz0 < 2) begin
        e.instr = in_instr;
        e.tag   = in_tag;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [63:0] e_imm;
      int e_fmt;
      bit e_ill;
      chk("in_ready32", {63'b0, rdy32}, {63'b0, q.size() < 2});
      chk("in_ready64", {63'b0, rdy64}, {63'b0, q.size() < 2});
      chk("out_valid32", {63'b0, vld32}, {63'b0, q.size() > 0});
      chk("out_valid64", {63'b0, vld64}, {63'b0, q.size() > 0});
      if (q.size() > 0) begin
        ref_dec(q[0].instr, 1'b0, e_imm, e_fmt, e_ill);
        chk("imm32", {32'b0, imm32}, e_imm);
        chk("fmt32", 64'(fmt32), 64'(e_fmt));
        chk("ill32", {63'b0, ill32}, {63'b0, e_ill});
        chk("tag32", {32'b0, tag32}, {32'b0, q[0].tag});
        ref_dec(q[0].instr, 1'b1, e_imm, e_fmt, e_ill);
        chk("imm64", imm64, e_imm);
        chk("fmt64", 64'(fmt64), 64'(e_fmt));
        chk("ill64", {63'b0, ill64}, {63'b0, e_ill});
        chk("tag64", {32'b0, tag64}, {32'b0, q[0].tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h73, 7'h13};
    int unsigned k;
    logic [31:0] r;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) r[6:0] = opcs[k];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mi;
    int mf;
    bit ml;

    // Model pins against hand-computed values.
    ref_dec(32'hFFF00093, 1'b0, mi, mf, ml);
    chk("pin_addi_imm", mi, 64'h0000_0000_FFFF_FFFF);
    chk("pin_addi_fmt", 64'(mf), 64'd1);
    ref_dec(32'hFE000EE3, 1'b1, mi, mf, ml);
    chk("pin_beq_imm", mi, 64'hFFFF_FFFF_FFFF_FFFC);
    ref_dec(32'h800000B7, 1'b1, mi, mf, ml);
    chk("pin_lui64", mi, 64'hFFFF_FFFF_8000_0000);
    ref_dec(32'h02009093, 1'b0, mi, mf, ml);
    chk("pin_slli_ill", {63'b0, ml}, 64'd1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;
    #1;
    chk("rst_valid", {63'b0, vld32}, 64'd0);
    chk("rst_ready", {63'b0, rdy32}, 64'd1);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", 64'(fmt32), 64'd0);
    chk("rst_ill", {63'b0, ill32}, 64'd0);
    chk("rst_tag", {32'b0, tag32}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // addi x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd100;
    tick();
    in_valid = 1'b0;
    neg();
    chk("addi_valid", {63'b0, vld32}, 64'd1);
    chk("addi_imm", {32'b0, imm32}, 64'hFFFF_FFFF);
    chk("addi_fmt", 64'(fmt32), 64'd1);
    chk("addi_ill", {63'b0, ill32}, 64'd0);
    tick();

    // beq -4 then jal 8, back to back
    in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 32'd101;
    tick();
    in_instr = 32'h0080006F; in_tag = 32'd102;
    neg();
    chk("beq_imm", {32'b0, imm32}, 64'hFFFF_FFFC);
    chk("beq_fmt", 64'(fmt32), 64'd3);
    tick();
    in_valid = 1'b0;
    neg();
    chk("jal_imm", {32'b0, imm32}, 64'h8);
    chk("jal_fmt", 64'(fmt32), 64'd5);
    tick(); tick();

    // Back-pressure with tags 1,2,3
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'd1;
    tick();
    in_tag = 32'd2;
    tick();
    in_tag = 32'd3;
    neg();
    chk("bp_ready_low", {63'b0, rdy32}, 64'd0);
    tick();
    neg();
    chk("bp_held_tag", {32'b0, tag32}, 64'd1);
    chk("bp_held_ready", {63'b0, rdy32}, 64'd0);
    out_ready = 1'b1;
    tick();
    neg();
    chk("bp_tag2", {32'b0, tag32}, 64'd2);
    chk("bp_ready_back", {63'b0, rdy32}, 64'd1);
    tick();
    in_valid = 1'b0;
    neg();
    chk("bp_tag3", {32'b0, tag32}, 64'd3);
    chk("bp_tag3_valid", {63'b0, vld32}, 64'd1);
    tick();

    // Illegal cases
    in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 32'd7;
    tick();
    in_instr = 32'h02009093; in_tag = 32'd8;
    neg();
    chk("zero_ill", {63'b0, ill32}, 64'd1);
    chk("zero_imm", {32'b0, imm32}, 64'd0);
    chk("zero_fmt", 64'(fmt32), 64'd0);
    tick();
    in_instr = 32'h800000B7; in_tag = 32'd9;
    neg();
    chk("slli32_ill", {63'b0, ill32}, 64'd1);
    chk("slli64_imm", imm64, 64'd32);
    chk("slli64_ill", {63'b0, ill64}, 64'd0);
    tick();
    in_instr = 32'h3052D073; in_tag = 32'd10;
    neg();
    chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui32_imm", {32'b0, imm32}, 64'h8000_0000);
    tick();
    in_valid = 1'b0;
    neg();
`ifdef IMM_GEN_CSR_EN
    chk("csr_imm", {32'b0, imm32}, 64'h5305);
    chk("csr_fmt", 64'(fmt32), 64'd7);
`else
    chk("csr_ill", {63'b0, ill32}, 64'd1);
    chk("csr_fmt", 64'(fmt32), 64'd0);
`endif
    tick();

    // Flush with skid full
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500113; in_tag = 32'hA1;
    tick();
    in_tag = 32'hA2;
    tick();
    flush = 1'b1; in_tag = 32'hA3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    neg();
    chk("flush_valid", {63'b0, vld32}, 64'd0);
    chk("flush_ready", {63'b0, rdy32}, 64'd1);

    // Flush with main full and a simultaneous accept
    in_valid = 1'b1; in_tag = 32'hB1;
    tick();
    flush = 1'b1; in_tag = 32'hB2;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("flush_gone", {63'b0, vld32}, 64'd0);
      tick();
    end

    // Reset in the middle of a transfer
    in_valid = 1'b1; out_ready = 1'b0; in_tag = 32'hC1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'b0, vld32}, 64'd0);
    chk("mid_rst_ready", {63'b0, rdy64}, 64'd1);
    tick();
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = rand_instr();
      in_tag    = 32'(c + 1000);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
